// File: rtl/lc3_writeback_arbiter.sv
// rtl/lc3_writeback_arbiter.sv - LC3 writeback arbiter: ALU/MEM round-robin onto the register file write port
// Owns the 8x16 register file and the NZP condition codes; reads bypass the pending WB write.
module lc3_writeback_arbiter #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int REG_AW = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_dr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_dr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              hold,
  input  logic [REG_AW-1:0] sr1,
  input  logic [REG_AW-1:0] sr2,
  output logic              writeback_en_out,
  output logic [2:0]        psr,
  output logic [DATA_W-1:0] VSR1,
  output logic [DATA_W-1:0] VSR2
);

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  logic              rr_last;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_dr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] regfile [NREG];

  // Grant is a function of valids, hold and rr_last only; data never feeds readies.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!hold) begin
      if (alu_valid && mem_valid) begin
        alu_ready = (rr_last == SRC_MEM);
        mem_ready = (rr_last == SRC_ALU);
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regfile[i] <= '0;
      psr      <= 3'b010;
      wb_valid <= 1'b0;
      wb_dr    <= '0;
      wb_data  <= '0;
      rr_last  <= SRC_ALU;
    end else begin
      // Commit is independent of hold: an accepted result always retires.
      if (wb_valid) begin
        regfile[wb_dr] <= wb_data;
        if (wb_data[DATA_W-1])  psr <= 3'b100;
        else if (wb_data == '0) psr <= 3'b010;
        else                    psr <= 3'b001;
      end
      wb_valid <= alu_ready || mem_ready;
      if (mem_ready) begin
        wb_dr   <= mem_dr;
        wb_data <= mem_data;
        rr_last <= SRC_MEM;
      end else if (alu_ready) begin
        wb_dr   <= alu_dr;
        wb_data <= alu_data;
        rr_last <= SRC_ALU;
      end
    end
  end

  assign writeback_en_out = wb_valid;

  // The value being committed this cycle is visible to the reader immediately.
  always_comb begin
    VSR1 = regfile[sr1];
    VSR2 = regfile[sr2];
    if (wb_valid && wb_dr == sr1) VSR1 = wb_data;
    if (wb_valid && wb_dr == sr2) VSR2 = wb_data;
  end

endmodule
